// File: rtl/paddle_game_core.sv
// paddle_game_core
//   Ball-and-paddle game engine for the VGA demo. One ball, one player
//   paddle, wall and paddle bounces, a SERVE/PLAY/OVER state machine, a
//   saturating hit counter and a lives counter. Game state advances once per
//   button_clk rising edge; the pixel colour is produced combinationally from
//   the current VGA coordinate and the sprite ROM bits.
//
//   Optional feature macro: PADDLE_GAME_SPEEDUP_EN. When defined, each paddle
//   hit that brings score[2:0] to zero raises the ball's vertical step by one,
//   up to BOX_Y_SPEED_MAX. When undefined the vertical step stays BOX_Y_SPEED.
//
// Ports
//   button_clk            game tick clock, rising edge
//   rst_n                 asynchronous active-low reset
//   button_left/right     active-low paddle movement buttons
//   button_start          active-low serve/restart, falling edge detected
//   x, y                  current pixel coordinate from the VGA timing
//   data_box, data_board  sprite bits at (px,py) and (bx,by)
//   r, g, b               pixel colour
//   px, py                ball sprite address (0 outside the ball)
//   bx, by                paddle sprite address (0 outside the paddle)
//   state                 0=SERVE 1=PLAY 2=OVER
//   score                 paddle hits, saturating
//   lives                 remaining lives
module paddle_game_core #(
  parameter int DRAW_W          = 640,
  parameter int DRAW_H          = 480,
  parameter int BOX_W           = 100,
  parameter int BOX_H           = 100,
  parameter int BOX_X_SPEED     = 1,
  parameter int BOX_Y_SPEED     = 1,
  parameter int BOX_Y_SPEED_MAX = 4,
  parameter int BOARD_Y         = 400,
  parameter int BOARD_H         = 50,
  parameter int BOARD_W         = 100,
  parameter int BOARD_SPEED     = 3,
  parameter int LIVES           = 3,
  parameter int SCORE_W         = 8
) (
  input  logic               button_clk,
  input  logic               rst_n,
  input  logic               button_left,
  input  logic               button_right,
  input  logic               button_start,
  input  logic [15:0]        x,
  input  logic [15:0]        y,
  input  logic               data_box,
  input  logic               data_board,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic [15:0]        px,
  output logic [15:0]        py,
  output logic [15:0]        bx,
  output logic [15:0]        by,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } game_state_t;

  localparam logic [15:0] SERVE_X    = 16'((DRAW_W - BOX_W) / 2);
  localparam logic [15:0] BOARD_X0   = 16'((DRAW_W - BOARD_W) / 2);
  localparam logic [15:0] HIT_Y      = 16'(BOARD_Y - BOX_H);
  localparam logic [15:0] VY_INIT    = 16'(BOX_Y_SPEED);
  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);
  localparam logic [15:0] BOARD_Y_U  = 16'(BOARD_Y);
  localparam logic [15:0] BOARD_H_U  = 16'(BOARD_H);
  localparam logic [16:0] BOX_W_U    = 17'(BOX_W);
  localparam logic [16:0] BOX_H_U    = 17'(BOX_H);
  localparam logic [16:0] BOARD_W_U  = 17'(BOARD_W);
  localparam logic [16:0] BOARD_BOT  = 17'(BOARD_Y + BOARD_H);

  localparam logic signed [16:0] BALL_X_MAX  = 17'(DRAW_W - BOX_W);
  localparam logic signed [16:0] BOARD_X_MAX = 17'(DRAW_W - BOARD_W);
  localparam logic signed [16:0] DRAW_H_S    = 17'(DRAW_H);
  localparam logic signed [16:0] BOX_W_S     = 17'(BOX_W);
  localparam logic signed [16:0] BOX_H_S     = 17'(BOX_H);
  localparam logic signed [16:0] BOARD_Y_S   = 17'(BOARD_Y);
  localparam logic signed [16:0] BOARD_W_S   = 17'(BOARD_W);
  localparam logic signed [16:0] X_STEP      = 17'(BOX_X_SPEED);
  localparam logic signed [16:0] PAD_STEP    = 17'(BOARD_SPEED);

  // With the feature off the step is zero and the ceiling never binds, so the
  // hit path leaves vy untouched while sharing one datapath.
`ifdef PADDLE_GAME_SPEEDUP_EN
  localparam logic [15:0] VY_STEP = 16'd1;
  localparam logic [15:0] VY_CEIL = 16'(BOX_Y_SPEED_MAX);
`else
  localparam logic [15:0] VY_STEP = 16'd0;
  localparam logic [15:0] VY_CEIL =
    16'((BOX_Y_SPEED_MAX > BOX_Y_SPEED) ? BOX_Y_SPEED_MAX : BOX_Y_SPEED);
`endif

  game_state_t        game_state, nxt_state;
  logic [15:0]        ball_x, nxt_ball_x;
  logic [15:0]        ball_y, nxt_ball_y;
  logic               dx_pos, nxt_dx_pos;
  logic               dy_down, nxt_dy_down;
  logic [15:0]        vy, nxt_vy;
  logic [15:0]        board_x, nxt_board_x;
  logic [SCORE_W-1:0] score_cnt, nxt_score;
  logic [3:0]         lives_cnt, nxt_lives;
  logic               start_q;

  logic               start_ev;
  logic signed [16:0] ball_x_s, ball_y_s, board_x_s, vy_s;
  logic signed [16:0] nx, ny, pad_left, pad_right;
  logic               miss, paddle_hit;
  logic [SCORE_W-1:0] score_hit;
  logic [15:0]        vy_bump;
  logic               in_box, in_board;

  assign state = game_state;
  assign score = score_cnt;
  assign lives = lives_cnt;

  // Signed 17-bit views so steps past the left/top edge go negative
  // instead of wrapping.
  assign ball_x_s  = signed'({1'b0, ball_x});
  assign ball_y_s  = signed'({1'b0, ball_y});
  assign board_x_s = signed'({1'b0, board_x});
  assign vy_s      = signed'({1'b0, vy});

  assign start_ev  = start_q & ~button_start;
  assign nx        = dx_pos  ? ball_x_s + X_STEP : ball_x_s - X_STEP;
  assign ny        = dy_down ? ball_y_s + vy_s   : ball_y_s - vy_s;
  assign pad_left  = board_x_s - PAD_STEP;
  assign pad_right = board_x_s + PAD_STEP;

  assign miss       = dy_down && (ny + BOX_H_S >= DRAW_H_S);
  assign paddle_hit = dy_down
                   && (ball_y_s + BOX_H_S <= BOARD_Y_S)
                   && (BOARD_Y_S < ny + BOX_H_S)
                   && (ball_x_s + BOX_W_S > board_x_s)
                   && (ball_x_s < board_x_s + BOARD_W_S);
  assign score_hit  = (score_cnt == '1) ? score_cnt : score_cnt + SCORE_W'(1);
  assign vy_bump    = vy + VY_STEP;

  always_ff @(posedge button_clk or negedge rst_n) begin
    if (!rst_n) begin
      game_state <= SERVE;
      ball_x     <= SERVE_X;
      ball_y     <= '0;
      dx_pos     <= 1'b1;
      dy_down    <= 1'b1;
      vy         <= VY_INIT;
      board_x    <= BOARD_X0;
      score_cnt  <= '0;
      lives_cnt  <= LIVES_INIT;
      start_q    <= 1'b1;
    end else begin
      game_state <= nxt_state;
      ball_x     <= nxt_ball_x;
      ball_y     <= nxt_ball_y;
      dx_pos     <= nxt_dx_pos;
      dy_down    <= nxt_dy_down;
      vy         <= nxt_vy;
      board_x    <= nxt_board_x;
      score_cnt  <= nxt_score;
      lives_cnt  <= nxt_lives;
      start_q    <= button_start;
    end
  end

  always_comb begin
    nxt_state   = game_state;
    nxt_ball_x  = ball_x;
    nxt_ball_y  = ball_y;
    nxt_dx_pos  = dx_pos;
    nxt_dy_down = dy_down;
    nxt_vy      = vy;
    nxt_board_x = board_x;
    nxt_score   = score_cnt;
    nxt_lives   = lives_cnt;

    if (game_state != OVER) begin
      if (!button_left && button_right) begin
        nxt_board_x = (pad_left < 17'sd0) ? '0 : pad_left[15:0];
      end else if (button_left && !button_right) begin
        nxt_board_x = (pad_right > BOARD_X_MAX) ? BOARD_X_MAX[15:0] : pad_right[15:0];
      end
    end

    case (game_state)
      SERVE: begin
        nxt_ball_x = SERVE_X;
        nxt_ball_y = '0;
        if (start_ev) begin
          nxt_state   = PLAY;
          nxt_dx_pos  = 1'b1;
          nxt_dy_down = 1'b1;
        end
      end
      PLAY: begin
        if (miss) begin
          nxt_lives = lives_cnt - 4'd1;
          if (lives_cnt == 4'd1) begin
            nxt_state = OVER;
          end else begin
            nxt_state  = SERVE;
            nxt_ball_x = SERVE_X;
            nxt_ball_y = '0;
          end
        end else begin
          if (nx < 17'sd0) begin
            nxt_ball_x = '0;
            nxt_dx_pos = 1'b1;
          end else if (nx > BALL_X_MAX) begin
            nxt_ball_x = BALL_X_MAX[15:0];
            nxt_dx_pos = 1'b0;
          end else begin
            nxt_ball_x = nx[15:0];
          end

          if (paddle_hit) begin
            nxt_ball_y  = HIT_Y;
            nxt_dy_down = 1'b0;
            nxt_score   = score_hit;
            if (score_hit[2:0] == 3'b000) begin
              nxt_vy = (vy_bump > VY_CEIL) ? VY_CEIL : vy_bump;
            end
          end else if (ny < 17'sd0) begin
            nxt_ball_y  = '0;
            nxt_dy_down = 1'b1;
          end else begin
            nxt_ball_y = ny[15:0];
          end
        end
      end
      OVER: begin
        if (start_ev) begin
          nxt_state   = SERVE;
          nxt_score   = '0;
          nxt_lives   = LIVES_INIT;
          nxt_vy      = VY_INIT;
          nxt_board_x = BOARD_X0;
          nxt_ball_x  = SERVE_X;
          nxt_ball_y  = '0;
        end
      end
      default: nxt_state = SERVE;
    endcase
  end

  assign in_box = ({1'b0, x} >= {1'b0, ball_x})
               && ({1'b0, x} <  {1'b0, ball_x} + BOX_W_U)
               && ({1'b0, y} >= {1'b0, ball_y})
               && ({1'b0, y} <  {1'b0, ball_y} + BOX_H_U);

  assign in_board = ({1'b0, x} >= {1'b0, board_x})
                 && ({1'b0, x} <  {1'b0, board_x} + BOARD_W_U)
                 && (y >= BOARD_Y_U)
                 && ({1'b0, y} < BOARD_BOT);

  assign px = in_box   ? x - ball_x : '0;
  assign py = in_box   ? y - ball_y : '0;
  assign bx = in_board ? x - board_x : '0;
  assign by = in_board ? BOARD_H_U - (y - BOARD_Y_U) : '0;

  // Ball is yellow (red+green) while playable and plain red once the game is over.
  assign r = in_box ? {8{data_box}} : '0;
  assign g = (in_box && game_state != OVER) ? {8{data_box}} : '0;
  assign b = in_board ? {8{data_board}} : '0;

endmodule

// File: tb/tb_paddle_game_core.sv
module tb_paddle_game_core;

  localparam int DRAW_W          = 640;
  localparam int DRAW_H          = 480;
  localparam int BOX_W           = 100;
  localparam int BOX_H           = 100;
  localparam int BOX_X_SPEED     = 1;
  localparam int BOX_Y_SPEED     = 1;
  localparam int BOX_Y_SPEED_MAX = 4;
  localparam int BOARD_Y         = 400;
  localparam int BOARD_H         = 50;
  localparam int BOARD_W         = 100;
  localparam int BOARD_SPEED     = 3;
  localparam int LIVES           = 3;
  localparam int SCORE_W         = 8;
  localparam int SERVE_X         = (DRAW_W - BOX_W) / 2;
  localparam int BOARD_X0        = (DRAW_W - BOARD_W) / 2;

  logic button_clk = 1'b0;
  logic rst_n;
  logic button_left, button_right, button_start;
  logic [15:0] x, y;
  logic data_box, data_board;
  logic [7:0] r, g, b;
  logic [15:0] px, py, bx, by;
  logic [1:0] state;
  logic [SCORE_W-1:0] score;
  logic [3:0] lives;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers, SERVE=0 PLAY=1 OVER=2)
  int m_state, m_ball_x, m_ball_y, m_dx, m_dy, m_vy, m_board, m_score, m_lives;
  bit m_start_q;

  paddle_game_core #(
    .DRAW_W(DRAW_W), .DRAW_H(DRAW_H), .BOX_W(BOX_W), .BOX_H(BOX_H),
    .BOX_X_SPEED(BOX_X_SPEED), .BOX_Y_SPEED(BOX_Y_SPEED),
    .BOX_Y_SPEED_MAX(BOX_Y_SPEED_MAX), .BOARD_Y(BOARD_Y), .BOARD_H(BOARD_H),
    .BOARD_W(BOARD_W), .BOARD_SPEED(BOARD_SPEED), .LIVES(LIVES), .SCORE_W(SCORE_W)
  ) dut (
    .button_clk(button_clk), .rst_n(rst_n),
    .button_left(button_left), .button_right(button_right), .button_start(button_start),
    .x(x), .y(y), .data_box(data_box), .data_board(data_board),
    .r(r), .g(g), .b(b), .px(px), .py(py), .bx(bx), .by(by),
    .state(state), .score(score), .lives(lives)
  );

  always #10 button_clk = ~button_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ball_x = SERVE_X; m_ball_y = 0; m_dx = 1; m_dy = 1;
    m_vy = BOX_Y_SPEED; m_board = BOARD_X0; m_score = 0; m_lives = LIVES;
    m_start_q = 1'b1;
  endtask

  // One game tick from the rules: inputs are raw active-low pin levels.
  task automatic model_step(input bit left, input bit right, input bit start);
    bit ev, hit;
    int old_board, nx, ny;
    ev = m_start_q && !start;
    old_board = m_board;
    if (m_state != 2) begin
      if (!left && right) m_board = (m_board - BOARD_SPEED < 0) ? 0 : m_board - BOARD_SPEED;
      else if (left && !right)
        m_board = (m_board + BOARD_SPEED > DRAW_W - BOARD_W) ? DRAW_W - BOARD_W : m_board + BOARD_SPEED;
    end
    case (m_state)
      0: begin
        m_ball_x = SERVE_X; m_ball_y = 0;
        if (ev) begin m_state = 1; m_dx = 1; m_dy = 1; end
      end
      1: begin
        nx = m_ball_x + m_dx * BOX_X_SPEED;
        ny = m_ball_y + m_dy * m_vy;
        if (m_dy > 0 && ny + BOX_H >= DRAW_H) begin
          if (m_lives == 1) m_state = 2;
          else begin m_state = 0; m_ball_x = SERVE_X; m_ball_y = 0; end
          m_lives = m_lives - 1;
        end else begin
          hit = (m_dy > 0) && (m_ball_y + BOX_H <= BOARD_Y) && (BOARD_Y < ny + BOX_H)
             && (m_ball_x + BOX_W > old_board) && (m_ball_x < old_board + BOARD_W);
          if (nx < 0) begin m_ball_x = 0; m_dx = 1; end
          else if (nx > DRAW_W - BOX_W) begin m_ball_x = DRAW_W - BOX_W; m_dx = -1; end
          else m_ball_x = nx;
          if (hit) begin
            m_ball_y = BOARD_Y - BOX_H; m_dy = -1;
            if (m_score < (1 << SCORE_W) - 1) m_score = m_score + 1;
`ifdef PADDLE_GAME_SPEEDUP_EN
            if (m_score % 8 == 0) m_vy = (m_vy + 1 > BOX_Y_SPEED_MAX) ? BOX_Y_SPEED_MAX : m_vy + 1;
`endif
          end else if (ny < 0) begin
            m_ball_y = 0; m_dy = 1;
          end else begin
            m_ball_y = ny;
          end
        end
      end
      default: begin
        if (ev) begin
          m_state = 0; m_score = 0; m_lives = LIVES; m_vy = BOX_Y_SPEED;
          m_board = BOARD_X0; m_ball_x = SERVE_X; m_ball_y = 0;
        end
      end
    endcase
    m_start_q = start;
  endtask

  task automatic probe(input int xi_in, input int yi_in, input bit db, input bit dbd);
    logic [15:0] xv, yv;
    int xi, yi;
    bit ib, ibd;
    logic [7:0] er, eg, eb;
    logic [15:0] epx, epy, ebx, eby;
    xv = 16'(xi_in); yv = 16'(yi_in);
    x = xv; y = yv; data_box = db; data_board = dbd;
    #1;
    xi = int'(xv); yi = int'(yv);
    ib  = xi >= m_ball_x && xi < m_ball_x + BOX_W && yi >= m_ball_y && yi < m_ball_y + BOX_H;
    ibd = xi >= m_board && xi < m_board + BOARD_W && yi >= BOARD_Y && yi < BOARD_Y + BOARD_H;
    er  = (ib && db) ? 8'hFF : 8'h00;
    eg  = (ib && db && m_state != 2) ? 8'hFF : 8'h00;
    eb  = (ibd && dbd) ? 8'hFF : 8'h00;
    epx = ib ? 16'(xi - m_ball_x) : 16'd0;
    epy = ib ? 16'(yi - m_ball_y) : 16'd0;
    ebx = ibd ? 16'(xi - m_board) : 16'd0;
    eby = ibd ? 16'(BOARD_H - (yi - BOARD_Y)) : 16'd0;
    check("pixel_rgb", {8'h00, r, g, b}, {8'h00, er, eg, eb});
    check("ball_addr", {px, py}, {epx, epy});
    check("board_addr", {bx, by}, {ebx, eby});
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_state));
    check("score", 32'(score), 32'(m_score));
    check("lives", 32'(lives), 32'(m_lives));
    probe(m_ball_x, m_ball_y, 1'b1, 1'b1);
    probe(m_ball_x + BOX_W - 1, m_ball_y + BOX_H - 1, 1'b1, 1'b0);
    probe(m_ball_x - 1, m_ball_y, 1'b1, 1'b1);
    probe(m_board, BOARD_Y, 1'b0, 1'b1);
    probe(m_board + BOARD_W, BOARD_Y + BOARD_H - 1, 1'b1, 1'b1);
    probe(int'($urandom_range(0, 699)), int'($urandom_range(0, 499)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic tick(input bit left, input bit right, input bit start);
    button_left = left; button_right = right; button_start = start;
    model_step(left, right, start);
    @(posedge button_clk);
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    button_left = 1'b1; button_right = 1'b1; button_start = 1'b1;
    x = '0; y = '0; data_box = 1'b0; data_board = 1'b0;
    model_reset();
    #15;
    check_all();
    #2 rst_n = 1'b1;

    // Idle after reset: everything stays at serve
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b1);
    check("idle_state", 32'(state), 32'd0);
    check("idle_lives", 32'(lives), 32'(LIVES));

    // Paddle saturation at both edges, then both buttons held
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1);

    // Randomized play with a paddle that mostly tracks the ball
    for (int i = 0; i < 4000; i++) begin
      bit l, rt, s;
      int bc, pc;
      l = 1'b1; rt = 1'b1;
      bc = m_ball_x + BOX_W / 2;
      pc = m_board + BOARD_W / 2;
      if ($urandom_range(0, 9) < 8) begin
        if (bc < pc - 10) l = 1'b0;
        else if (bc > pc + 10) rt = 1'b0;
      end else begin
        l = 1'($urandom_range(0, 1));
        rt = 1'($urandom_range(0, 1));
      end
      s = ($urandom_range(0, 5) != 0);
      tick(l, rt, s);
    end

    // Asynchronous reset in the middle of a cycle
    button_left = 1'b1; button_right = 1'b1; button_start = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #2 rst_n = 1'b1;

    // Paddle parked at the left edge, keep serving until the game is over
    for (int i = 0; i < 3000 && m_state != 2; i++)
      tick(1'b0, 1'b1, (i % 8 == 0) ? 1'b0 : 1'b1);
    check("reach_over", 32'(state), 32'd2);

    // Paddle frozen in OVER
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);

    // Start held low: exactly one restart
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0);
    check("restart_state", 32'(state), 32'd0);
    check("restart_lives", 32'(lives), 32'(LIVES));
    check("restart_score", 32'(score), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
